// File: rtl/mem_responder.sv
// rtl/mem_responder.sv - handshaked word memory responder with lw/lhu/lbu loads and RMW sub-word stores
module mem_responder #(
  parameter int ADDR_W      = 8,
  parameter int WAIT_CYCLES = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req,
  input  logic        we,
  input  logic [1:0]  size,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        ready,
  output logic        err
);

  localparam int CNT_W = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] WAIT_LOAD = (WAIT_CYCLES > 0) ? CNT_W'(WAIT_CYCLES - 1) : '0;

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT,
    S_ACCESS,
    S_MERGE,
    S_RESP
  } state_t;

  state_t              state;
  state_t              state_nxt;
  logic                we_q;
  logic [1:0]          size_q;
  logic [ADDR_W+1:0]   addr_q;
  logic [31:0]         wdata_q;
  logic                err_q;
  logic [CNT_W-1:0]    wait_cnt;
  logic [31:0]         merge_q;
  logic [31:0]         mem [2**ADDR_W];

  logic                misaligned;
  logic [ADDR_W-1:0]   idx;
  logic [1:0]          lane;
  logic [31:0]         word_rd;
  logic [31:0]         load_val;
  logic [31:0]         merged;
  logic                mem_we;
  logic [31:0]         mem_wdata;
  logic                unused_addr_bits;

  // Address bits above the array span only alias onto lower words.
  assign unused_addr_bits = ^addr[31:ADDR_W+2];

  assign misaligned = (size == 2'b11) ||
                      ((size == 2'b00) && (addr[1:0] != 2'b00)) ||
                      ((size == 2'b01) && addr[0]);

  assign idx     = addr_q[ADDR_W+1:2];
  assign lane    = addr_q[1:0];
  assign word_rd = mem[idx];

  // Pick the addressed lane of the stored word and zero-extend it.
  always_comb begin
    load_val = word_rd;
    case (size_q)
      2'b01: load_val = lane[1] ? {16'h0000, word_rd[31:16]} : {16'h0000, word_rd[15:0]};
      2'b10: begin
        case (lane)
          2'd0:    load_val = {24'h000000, word_rd[7:0]};
          2'd1:    load_val = {24'h000000, word_rd[15:8]};
          2'd2:    load_val = {24'h000000, word_rd[23:16]};
          default: load_val = {24'h000000, word_rd[31:24]};
        endcase
      end
      default: load_val = word_rd;
    endcase
  end

  // Overlay the store data onto the captured word for the write-back.
  always_comb begin
    merged = merge_q;
    if (size_q == 2'b01) begin
      if (lane[1]) merged[31:16] = wdata_q[15:0];
      else         merged[15:0]  = wdata_q[15:0];
    end else begin
      case (lane)
        2'd0:    merged[7:0]   = wdata_q[7:0];
        2'd1:    merged[15:8]  = wdata_q[7:0];
        2'd2:    merged[23:16] = wdata_q[7:0];
        default: merged[31:24] = wdata_q[7:0];
      endcase
    end
  end

  // State register; reset aborts any transaction in flight.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= S_IDLE;
    else        state <= state_nxt;
  end

  // Next-state, array write strobe and response outputs.
  always_comb begin
    state_nxt = state;
    ready     = 1'b0;
    err       = 1'b0;
    mem_we    = 1'b0;
    mem_wdata = wdata_q;
    case (state)
      S_IDLE: begin
        if (req) begin
          if (misaligned)            state_nxt = S_RESP;
          else if (WAIT_CYCLES > 0)  state_nxt = S_WAIT;
          else                       state_nxt = S_ACCESS;
        end
      end
      S_WAIT: begin
        if (wait_cnt == '0) state_nxt = S_ACCESS;
      end
      S_ACCESS: begin
        if (we_q && (size_q != 2'b00)) begin
          state_nxt = S_MERGE;
        end else begin
          mem_we    = we_q;
          state_nxt = S_RESP;
        end
      end
      S_MERGE: begin
        mem_we    = 1'b1;
        mem_wdata = merged;
        state_nxt = S_RESP;
      end
      S_RESP: begin
        ready     = 1'b1;
        err       = err_q;
        state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // Request capture, wait countdown, load result and merge capture.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      we_q     <= 1'b0;
      size_q   <= 2'b00;
      addr_q   <= '0;
      wdata_q  <= 32'h0;
      err_q    <= 1'b0;
      wait_cnt <= '0;
      merge_q  <= 32'h0;
      rdata    <= 32'h0;
    end else begin
      case (state)
        S_IDLE: begin
          if (req) begin
            we_q     <= we;
            size_q   <= size;
            addr_q   <= addr[ADDR_W+1:0];
            wdata_q  <= wdata;
            err_q    <= misaligned;
            wait_cnt <= WAIT_LOAD;
          end
        end
        S_WAIT: begin
          if (wait_cnt != '0) wait_cnt <= wait_cnt - 1'b1;
        end
        S_ACCESS: begin
          if (!we_q)                     rdata   <= load_val;
          else if (size_q != 2'b00)      merge_q <= word_rd;
        end
        default: ;
      endcase
    end
  end

  // Storage array; not reset, written only from ACCESS or MERGE.
  always_ff @(posedge clk) begin
    if (mem_we) mem[idx] <= mem_wdata;
  end

endmodule

// File: tb/tb_mem_responder.sv
// tb/tb_mem_responder.sv - scoreboard bench for mem_responder
module tb_mem_responder;

  logic             clk = 1'b0;
  logic             reset;
  logic [1:0]       req;
  logic [1:0]       we;
  logic [1:0]       ready;
  logic [1:0]       err;
  logic [1:0][1:0]  size;
  logic [1:0][31:0] addr;
  logic [1:0][31:0] wdata;
  logic [1:0][31:0] rdata;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          lat;
    string       tag;
  } exp_t;

  exp_t        sbq[$];
  logic [31:0] mdl [2][256];
  logic [31:0] held [2];
  int          checks = 0;
  int          errors = 0;

  always #5 clk = ~clk;

  mem_responder #(.ADDR_W(8), .WAIT_CYCLES(1)) dut_w1 (
    .clk(clk), .reset(reset), .req(req[0]), .we(we[0]), .size(size[0]),
    .addr(addr[0]), .wdata(wdata[0]), .rdata(rdata[0]), .ready(ready[0]), .err(err[0])
  );

  mem_responder #(.ADDR_W(8), .WAIT_CYCLES(0)) dut_w0 (
    .clk(clk), .reset(reset), .req(req[1]), .we(we[1]), .size(size[1]),
    .addr(addr[1]), .wdata(wdata[1]), .rdata(rdata[1]), .ready(ready[1]), .err(err[1])
  );

  task automatic check(string tag, logic [31:0] got, logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got=%h want=%h", tag, got, want);
    end
  endtask

  function automatic bit is_mis(logic [1:0] sz, logic [31:0] a);
    return (sz == 2'b11) || ((sz == 2'b00) && (a[1:0] != 2'b00)) || ((sz == 2'b01) && a[0]);
  endfunction

  task automatic push_exp(int u, bit w, logic [1:0] sz, logic [31:0] a, logic [31:0] d, string tag);
    exp_t        e;
    int          i;
    int          sh;
    logic [31:0] m;
    logic [31:0] mask;
    i      = int'(a[9:2]);
    m      = mdl[u][i];
    e.tag  = tag;
    e.err  = is_mis(sz, a);
    if (e.err) e.lat = 1;
    else       e.lat = ((u == 0) ? 1 : 0) + ((w && (sz != 2'b00)) ? 3 : 2);
    if (!e.err) begin
      if (sz == 2'b00)      begin sh = 0;                 mask = 32'hFFFF_FFFF; end
      else if (sz == 2'b01) begin sh = 16 * int'(a[1]);   mask = 32'h0000_FFFF; end
      else                  begin sh = 8 * int'(a[1:0]);  mask = 32'h0000_00FF; end
      if (!w) held[u]    = (m >> sh) & mask;
      else    mdl[u][i]  = (m & ~(mask << sh)) | ((d & mask) << sh);
    end
    e.rdata = held[u];
    sbq.push_back(e);
  endtask

  task automatic wait_resp(int u);
    int   lat;
    exp_t e;
    lat = 1;
    while (!ready[u] && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    e = sbq.pop_front();
    check({e.tag, ".ready"}, 32'(ready[u]), 32'd1);
    check({e.tag, ".lat"},   lat,          e.lat);
    check({e.tag, ".err"},   32'(err[u]),  32'(e.err));
    check({e.tag, ".rdata"}, rdata[u],     e.rdata);
    @(posedge clk); #1;
    check({e.tag, ".pulse"}, 32'(ready[u]), 32'd0);
  endtask

  task automatic drive(int u, bit w, logic [1:0] sz, logic [31:0] a, logic [31:0] d);
    @(negedge clk);
    req[u]   = 1'b1;
    we[u]    = w;
    size[u]  = sz;
    addr[u]  = a;
    wdata[u] = d;
    @(posedge clk); #1;
  endtask

  task automatic txn(int u, bit w, logic [1:0] sz, logic [31:0] a, logic [31:0] d, string tag);
    push_exp(u, w, sz, a, d, tag);
    drive(u, w, sz, a, d);
    req[u] = 1'b0;
    wait_resp(u);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog ready never came");
    $fatal(1);
  end

  initial begin
    reset = 1'b0;
    req   = '0;
    we    = '0;
    size  = '0;
    addr  = '0;
    wdata = '0;
    held[0] = 32'h0;
    held[1] = 32'h0;
    for (int u = 0; u < 2; u++)
      for (int i = 0; i < 256; i++) mdl[u][i] = 32'h0;

    @(posedge clk); #1;
    check("rst_ready", 32'(ready), 32'd0);
    check("rst_err",   32'(err),   32'd0);
    check("rst_rdata0", rdata[0], 32'h0);
    check("rst_rdata1", rdata[1], 32'h0);
    @(posedge clk);
    @(negedge clk);
    reset = 1'b1;

    txn(0, 1, 2'b00, 32'h10, 32'hDEADBEEF, "st_word");
    txn(0, 0, 2'b00, 32'h10, 32'h0, "ld_word");
    check("plan_word", rdata[0], 32'hDEADBEEF);
    txn(0, 0, 2'b10, 32'h13, 32'h0, "lbu_13");
    check("plan_lbu13", rdata[0], 32'h000000DE);
    txn(0, 0, 2'b01, 32'h10, 32'h0, "lhu_10");
    check("plan_lhu10", rdata[0], 32'h0000BEEF);
    txn(0, 0, 2'b10, 32'h11, 32'h0, "lbu_11");
    check("plan_lbu11", rdata[0], 32'h000000BE);
    txn(0, 1, 2'b10, 32'h12, 32'h000000AA, "sb_12");
    txn(0, 1, 2'b01, 32'h10, 32'hFFFF1234, "sh_10");
    txn(0, 0, 2'b00, 32'h10, 32'h0, "ld_rmw");
    check("plan_rmw", rdata[0], 32'hDEAA1234);

    txn(0, 0, 2'b00, 32'h11, 32'h0, "mis_lw");
    txn(0, 1, 2'b01, 32'h13, 32'h5555, "mis_sh");
    txn(0, 0, 2'b11, 32'h10, 32'h0, "mis_sz");
    check("mis_rdata", rdata[0], 32'hDEAA1234);
    txn(0, 0, 2'b00, 32'h10, 32'h0, "mis_keep");
    check("plan_mis_keep", rdata[0], 32'hDEAA1234);

    for (int k = 0; k < 4; k++)
      txn(0, 1, 2'b00, 32'h40 + 32'(4 * k), $urandom, $sformatf("init%0d", k));
    for (int k = 0; k < 40; k++) begin
      logic [31:0] a;
      a = (32'h40 + 32'($urandom_range(0, 15))) | (32'($urandom_range(0, 3)) << 10);
      txn(0, 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), a, $urandom,
          $sformatf("rnd%0d", k));
    end

    txn(1, 1, 2'b00, 32'h400, 32'h5, "wrap_st");
    txn(1, 0, 2'b00, 32'h0, 32'h0, "wrap_ld");
    check("plan_wrap", rdata[1], 32'h5);
    txn(1, 1, 2'b00, 32'h4, 32'h77, "st_4");

    push_exp(1, 0, 2'b00, 32'h0, 32'h0, "hold_a");
    push_exp(1, 0, 2'b00, 32'h4, 32'h0, "hold_b");
    drive(1, 0, 2'b00, 32'h0, 32'h0);
    wait_resp(1);
    addr[1] = 32'h4;
    @(posedge clk); #1;
    req[1] = 1'b0;
    wait_resp(1);
    check("reaccept_val", rdata[1], 32'h77);

    txn(0, 1, 2'b00, 32'h20, 32'h11223344, "pre_st");
    txn(0, 0, 2'b00, 32'h10, 32'h0, "pre_ld");
    check("pre_rd", rdata[0], 32'hDEAA1234);
    drive(0, 1, 2'b10, 32'h20, 32'h000000FF);
    req[0] = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    reset = 1'b0;
    #1;
    check("midrst_ready",  32'(ready[0]), 32'd0);
    check("midrst_err",    32'(err[0]),   32'd0);
    check("midrst_rdata0", rdata[0],      32'h0);
    check("midrst_rdata1", rdata[1],      32'h0);
    @(posedge clk);
    @(negedge clk);
    reset   = 1'b1;
    held[0] = 32'h0;
    held[1] = 32'h0;
    txn(0, 0, 2'b00, 32'h20, 32'h0, "post_ld");
    check("plan_post", rdata[0], 32'h11223344);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_responder.md
# mem_responder

Word-organised data memory acting as the responder end of the processor's load/store interface. Accepts one request at a time over a req/ready handshake and returns zero-extended word, halfword or byte reads (lw/lhu/lbu). Performs halfword and byte stores as an internal read-modify-write on a word-wide array. Sits between the multicycle datapath's address/write-data path and the storage array, replacing the fixed-latency memory with a handshaked one.

## Interface
- ADDR_W, 8: word-index bits; depth = 2**ADDR_W words
- WAIT_CYCLES, 1: extra wait states inserted before every array access (0 allowed)

- clk  in  1  clock, rising-edge
- reset  in  1  asynchronous, active-low reset
- req  in  1  request valid; level, sampled only in IDLE
- we  in  1  1 = store, 0 = load
- size  in  2  00 word, 01 halfword, 10 byte; 11 treated as misaligned
- addr  in  32  byte address
- wdata  in  32  store data; half/byte taken from the low 16/8 bits
- rdata  out  32  load data, zero-extended; held until the next successful load completes
- ready  out  1  one-cycle completion pulse
- err  out  1  valid with ready; 1 = misaligned or illegal size, no access performed

## Operation
- States: IDLE, WAIT, ACCESS, MERGE, RESP.
- IDLE: on an edge with req=1, latch we/size/addr/wdata and check alignment.
  - Misaligned: word with addr[1:0]≠0, half with addr[0]=1, or size=11. Go to RESP with err=1.
  - Otherwise go to WAIT if WAIT_CYCLES>0, else to ACCESS.
- WAIT: the counter loads WAIT_CYCLES-1 on accept and decrements each cycle; at 0, go to ACCESS.
- ACCESS: word index = addr[ADDR_W+1:2]. Upper address bits are ignored, so addresses wrap modulo 4·2**ADDR_W.
  - Load: rdata <= selected lane, zero-extended; go to RESP.
  - Word store: array[idx] <= wdata; go to RESP.
  - Half/byte store: capture array[idx] into the merge register; go to MERGE.
- MERGE: replace the addressed lane with wdata[15:0] or wdata[7:0]; write the merged word back; go to RESP.
- Lane selection is little-endian: byte addr[1:0]=0 is bits 7:0, 3 is bits 31:24; half addr[1]=0 is bits 15:0, 1 is bits 31:16.
- RESP: ready=1 and err as determined; go to IDLE unconditionally.
  - req is not sampled in RESP.
  - The requester drops req in the ready cycle. If req is still high in the following IDLE cycle, it is taken as a new request.
- A misaligned request never modifies the array or rdata.

## Timing
- Reset (reset=0, asynchronous): state IDLE, ready 0, err 0, rdata 0, wait counter 0, merge register 0. Array contents are not reset.
- Reset mid-operation aborts immediately.
  - A store whose write edge has not occurred is lost.
  - A half/byte store reset in MERGE leaves the array unchanged.
- Latency is counted from the accept edge to the cycle with ready=1 (W = WAIT_CYCLES):
  - load and word store: W+2 cycles
  - half/byte store: W+3 cycles
  - misaligned: 1 cycle
- Minimum spacing between accepts: latency+1 cycles.
- rdata changes only on the ACCESS edge of a successful load.
- The store value is visible to a load accepted after ready.

## Test plan
- Reset then word traffic (W=1): store 0xDEADBEEF at 0x10 → ready 3 cycles after accept, err=0. Load word 0x10 → rdata=0xDEADBEEF, 3-cycle latency.
- Sub-word loads: after the above, lbu 0x13 → 0x000000DE; lhu 0x10 → 0x0000BEEF; lbu 0x11 → 0x000000BE.
- Read-modify-write: store byte 0xAA at 0x12 → ready 4 cycles after accept. Store half 0x1234 at 0x10. Load word 0x10 → 0xDEAA1234.
- Misalignment: word load at 0x11, half store at 0x13, size=11 → each returns ready 1 cycle after accept with err=1. Array and rdata are unchanged (word 0x10 still 0xDEAA1234).
- Wrap and WAIT_CYCLES=0 (ADDR_W=8): store 0x5 at 0x400 → load 0x0 returns 0x5. Word latency is 2 cycles. Holding req high through RESP causes re-accept in the next IDLE cycle.
- Reset mid-op: assert reset during MERGE of a byte store to 0x20 that previously held 0x11223344 → ready/err/rdata drop to 0 immediately. After release, load 0x20 → 0x11223344.
